// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control FSM: state encodings, opcodes,
// ALU operation codes and datapath mux selects.
package mc_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] RESET_S   = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] EXEC_R    = 4'd3;
  localparam logic [3:0] R_WB      = 4'd4;
  localparam logic [3:0] MEM_ADDR  = 4'd5;
  localparam logic [3:0] MEM_READ  = 4'd6;
  localparam logic [3:0] MEM_WB    = 4'd7;
  localparam logic [3:0] MEM_WRITE = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] JUMP      = 4'd10;
  localparam logic [3:0] ADDI_EXEC = 4'd11;
  localparam logic [3:0] ADDI_WB   = 4'd12;
  localparam logic [3:0] TRAP      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SUB   = 3'b010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  // States that wait on mem_ready and therefore run the wait counter.
  function automatic logic is_mem_state(logic [3:0] st);
    return (st == FETCH) || (st == MEM_READ) || (st == MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
  parameter int unsigned ALUOP_W = 3
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_we;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               mem_err;
  logic [3:0]         state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_we, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, mem_err, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_we, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, mem_err, state_o
  );
endinterface

// File: rtl/mc_mem_wait.sv
// Memory wait counter: counts mem_ready=0 cycles in a memory state and flags a timeout.
// MEM_TIMEOUT = 0 disables the timeout entirely.
module mc_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_done,
  output logic o_timeout
);
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_at_limit;

  assign w_at_limit = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(LIMIT));
  assign o_done     = i_active & i_ready;
  // A ready on the limit cycle completes normally, so timeout requires ready low.
  assign o_timeout  = i_active & ~i_ready & w_at_limit;

  // Any exit from waiting (done, timeout, or idle) leaves the counter at zero for the next entry.
  always_comb begin
    w_cnt_next = '0;
    if (i_active && !i_ready && !w_at_limit) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM. Define ILLEGAL_TRAP_EN to trap on unknown opcodes
// (otherwise they execute as a NOP).
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_control_if.master  bus
);
  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_done;
  logic       w_timeout;
  ctrl_t      w_ctrl;

  mc_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk      (clk),
    .rst      (rst),
    .i_active (is_mem_state(r_state)),
    .i_ready  (bus.mem_ready),
    .o_done   (w_done),
    .o_timeout(w_timeout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      RESET_S: w_next = FETCH;
      FETCH: begin
        if (w_done) w_next = DECODE;
        else if (w_timeout) w_next = FETCH;
      end
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_next = EXEC_R;
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDI_EXEC;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = TRAP;
`else
          default:      w_next = FETCH;
`endif
        endcase
      end
      EXEC_R:    w_next = R_WB;
      MEM_ADDR:  w_next = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: begin
        if (w_done) w_next = MEM_WB;
        else if (w_timeout) w_next = FETCH;
      end
      MEM_WRITE: begin
        if (w_done || w_timeout) w_next = FETCH;
      end
      ADDI_EXEC: w_next = ADDI_WB;
      R_WB, MEM_WB, BRANCH, JUMP, ADDI_WB: w_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:      w_next = TRAP;
`endif
      default:   w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_S;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = w_done;
        w_ctrl.pc_write  = w_done;
      end
      DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_op    = ALUOP_RTYPE;
      end
      R_WB: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      MEM_ADDR, ADDI_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.mem_read = 1'b1;
      end
      MEM_WB: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_RT;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_ctrl.pc_write_cond = 1'b1;
      end
      JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_write  = 1'b1;
      end
      ADDI_WB: w_ctrl.reg_write = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  assign bus.pc_we      = w_ctrl.pc_write | (w_ctrl.pc_write_cond & bus.zero);
  assign bus.iord       = w_ctrl.iord;
  assign bus.mem_read   = w_ctrl.mem_read;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.ir_write   = w_ctrl.ir_write;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.alu_op     = ALUOP_W'(w_ctrl.alu_op);
  assign bus.pc_source  = w_ctrl.pc_source;
  assign bus.mem_err    = w_timeout;
  assign bus.state_o    = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control; honours ILLEGAL_TRAP_EN like the RTL.
module tb_multicycle_control;
  localparam int TO = 16;

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_R_WB  = 4'd4,  S_MADDR = 4'd5,  S_MREAD  = 4'd6, S_MWB    = 4'd7;
  localparam logic [3:0] S_MWR   = 4'd8,  S_BEQ   = 4'd9,  S_JUMP   = 4'd10, S_ADDIX = 4'd11;
  localparam logic [3:0] S_ADDIW = 4'd12, S_TRAP  = 4'd13;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       err;
  } step_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_checks = 0;
  int    n_errors = 0;
  step_t q[$];

  multicycle_control_if #(.ALUOP_W(3)) bus ();

  multicycle_control #(
    .ALUOP_W    (3),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control vector straight from the per-state output table.
  function automatic logic [16:0] exp_out(logic [3:0] st, logic rdy, logic z, logic err);
    logic pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] op;
    {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; ps = 2'b00; op = 3'b000;
    case (st)
      S_FETCH:  begin mr = 1; sb = 2'b01; op = 3'b001; irw = rdy; pcw = rdy; end
      S_DECODE: begin sb = 2'b11; op = 3'b001; end
      S_EXEC_R: sa = 1;
      S_R_WB:   begin rd = 1; rw = 1; end
      S_MADDR, S_ADDIX: begin sa = 1; sb = 2'b10; op = 3'b001; end
      S_MREAD:  begin iord = 1; mr = 1; end
      S_MWB:    begin m2r = 1; rw = 1; end
      S_MWR:    begin iord = 1; mw = 1; end
      S_BEQ:    begin sa = 1; op = 3'b010; ps = 2'b01; pcc = 1; end
      S_JUMP:   begin ps = 2'b10; pcw = 1; end
      S_ADDIW:  rw = 1;
      default: ;
    endcase
    return {pcw | (pcc & z), iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, err};
  endfunction

  function automatic logic [16:0] obs_out();
    return {bus.pc_we, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
            bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.mem_err};
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // A memory phase: 'waits' not-ready cycles then a ready cycle, or a timeout.
  task automatic add_mem(input logic [3:0] st, input int waits, output bit timed_out);
    if (waits >= TO) begin
      for (int i = 0; i < TO; i++) q.push_back('{st, 1'b0, (i == TO - 1)});
      timed_out = 1;
    end else begin
      for (int i = 0; i < waits; i++) q.push_back('{st, 1'b0, 1'b0});
      q.push_back('{st, 1'b1, 1'b0});
      timed_out = 0;
    end
  endtask

  task automatic push_plain(input logic [3:0] st);
    q.push_back('{st, 1'($urandom_range(0, 1)), 1'b0});
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns there (or in TRAP).
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int zmode);
    bit to;
    q.delete();
    add_mem(S_FETCH, fw, to);
    if (!to) begin
      push_plain(S_DECODE);
      case (op)
        6'b000000: begin push_plain(S_EXEC_R); push_plain(S_R_WB); end
        6'b100011: begin
          push_plain(S_MADDR);
          add_mem(S_MREAD, mw, to);
          if (!to) push_plain(S_MWB);
        end
        6'b101011: begin push_plain(S_MADDR); add_mem(S_MWR, mw, to); end
        6'b000100: push_plain(S_BEQ);
        6'b000010: push_plain(S_JUMP);
        6'b001000: begin push_plain(S_ADDIX); push_plain(S_ADDIW); end
        default: begin
`ifdef ILLEGAL_TRAP_EN
          for (int i = 0; i < 4; i++) push_plain(S_TRAP);
`endif
        end
      endcase
    end
    bus.opcode = op;
    foreach (q[i]) begin
      bus.mem_ready = q[i].rdy;
      bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #4;
      check_eq($sformatf("state op=%b step=%0d", op, i), 32'(bus.state_o), 32'(q[i].st));
      check_eq($sformatf("ctrl op=%b st=%0d", op, q[i].st), 32'(obs_out()),
               32'(exp_out(q[i].st, q[i].rdy, bus.zero, q[i].err)));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_state", 32'(bus.state_o), 32'(S_RESET));
      check_eq("reset_outputs", 32'(obs_out()), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic maybe_reset(input logic [5:0] op);
`ifdef ILLEGAL_TRAP_EN
    if (!is_legal(op)) do_reset();
`else
    if (!is_legal(op)) begin end
`endif
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int fw, mw;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    bus.opcode = 6'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    do_reset();

    run_instr(6'b000000, 0, 0, -1);   // add
    run_instr(6'b100011, 0, 3, -1);   // lw, 3 wait cycles in MEM_READ
    run_instr(6'b000100, 0, 0, 1);    // beq taken
    run_instr(6'b000100, 0, 0, 0);    // beq not taken
    run_instr(6'b000000, TO + 2, 0, -1);  // fetch timeout
    run_instr(6'b101011, 1, TO, -1);  // sw timeout
    run_instr(6'b000010, 0, 0, -1);   // j
    run_instr(6'b111111, 0, 0, -1);
    maybe_reset(6'b111111);

    // Mid-instruction reset: abort during MEM_READ wait.
    bus.opcode = 6'b100011;
    bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    #4;
    check_eq("midrst_in_memread", 32'(bus.state_o), 32'(S_MREAD));
    @(posedge clk);
    #1;
    do_reset();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 12) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      fw = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      if (fw == TO - 1) fw = TO - 1;
      run_instr(op, fw, mw, -1);
      maybe_reset(op);
    end

    // Ready arriving on the last allowed cycle completes normally.
    run_instr(6'b100011, TO - 1, TO - 1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback over several clocks. It drives the datapath mux selects and write enables, and supplies the 3-bit ALU operation code to the ALU control block. Memory accesses use a ready handshake with an optional timeout.

Parameters:
ALUOP_W, 3, width of alu_op output (encoding in package)
MEM_TIMEOUT, 16, max wait cycles for mem_ready per access; 0 = wait forever

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
opcode  input  6  instr[31:26], sampled from the IR in DECODE
zero  input  1  ALU zero flag, used in BRANCH
mem_ready  input  1  memory has completed the current read/write this cycle
pc_we  output  1  PC load enable = pc_write | (pc_write_cond & zero)
iord  output  1  0 = address from PC, 1 = address from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load the IR
mem_to_reg  output  1  writeback source: 1 = MDR, 0 = ALUOut
reg_dst  output  1  1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  output  ALUOP_W  000 = R-type (use funct), 001 = ADD, 010 = SUB
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
mem_err  output  1  one-cycle pulse on memory timeout
state_o  output  4  current state, for debug

Behaviour:
- All outputs are Moore (decoded from the state), except pc_we, which combines state and zero. Only rst is synchronous. The state register and wait counter update on the rising clk edge.
- rst=1: state becomes RESET_S on the next edge. In RESET_S every output is 0 and state_o=0. The FSM goes to FETCH on the first edge with rst=0. A reset mid-instruction aborts it with no writes.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. The FSM holds until mem_ready=1. In that cycle only, ir_write=1 and pc_write=1, and the FSM moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - other → ILLEGAL handling
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=000. Next state R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: iord=1, mem_read=1. The FSM holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEM_WRITE: iord=1, mem_write=1. The FSM holds until mem_ready, then goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_write_cond=1. Next state FETCH.
- JUMP: pc_source=10, pc_write=1. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
- Latency: R-type, addi and sw take 4 cycles; lw takes 5; beq and j take 3. Each memory state adds 1 cycle per mem_ready=0 cycle.
- Wait counter:
  - Clears on entry to any memory state.
  - Increments each cycle mem_ready=0 while in FETCH, MEM_READ or MEM_WRITE.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT-1 with mem_ready still 0, mem_err=1 for that cycle and the FSM goes to FETCH. No ir_write, pc_write or reg_write occurs.
  - mem_ready=1 on the same cycle as the timeout wins: normal completion, no error.
- Unreachable state encodings go to FETCH on the next edge.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds with all enables 0 and state_o=TRAP until rst.
- Undefined: an unknown opcode is a NOP; DECODE → FETCH with no writes.

Decomposition:
- Package mc_pkg holds:
  - state encodings (4-bit): RESET_S=0, FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP
  - opcode constants
  - ALUOp constants ALUOP_RTYPE/ADD/SUB
  - alu_src_b and pc_source select constants
- One sub-module, mc_mem_wait: wait counter plus timeout compare. It outputs done and timeout.

Test Plan:
- rst=1 for 2 cycles, then release → all outputs 0 during reset; state_o=FETCH one cycle after release; mem_read=1.
- add (opcode 000000), mem_ready=1 always → state sequence FETCH, DECODE, EXEC_R, R_WB; alu_op=000 in EXEC_R; reg_write=1 and reg_dst=1 only in R_WB.
- lw with mem_ready low 3 cycles in MEM_READ → MEM_READ held 4 cycles; MEM_WB has mem_to_reg=1 and reg_write=1; total 8 cycles.
- beq: zero=1 → pc_we=1 in BRANCH; zero=0 → pc_we=0; alu_op=010 in both cases.
- MEM_TIMEOUT=16, mem_ready stuck 0 in FETCH → mem_err pulses on the 16th cycle; next state FETCH; ir_write never 1.
- opcode 111111 → with ILLEGAL_TRAP_EN, state_o=TRAP and stays there; without it, returns to FETCH with no write enables asserted.
